// File: rtl/alu_regfile_ctrl.sv
// Triggered register-file calculator: one command per rising edge of trigger.
// Define ALU_MUL_EN to compile in the multi-cycle shift-add multiplier (op 8).
module alu_regfile_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int SW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic [3:0]       op,
  input  logic [SW-1:0]    sel_a,
  input  logic [SW-1:0]    sel_b,
  input  logic [SW-1:0]    sel_d,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] view_a,
  output logic [WIDTH-1:0] view_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t           state_q, state_d;
  logic             trig_q;
  logic             trig_edge;
  logic [WIDTH-1:0] regs [NREGS];

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, din_q;
  logic [SW-1:0]    sel_a_q, sel_b_q, sel_d_q;

  logic [WIDTH+1:0] alu;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;
  logic [SW-1:0]      sel_hi;

  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign sel_hi   = sel_d_q + 1'b1;
`endif

  function automatic logic is_reserved(input logic [3:0] o);
`ifdef ALU_MUL_EN
    return (o >= 4'hA) && (o <= 4'hC);
`else
    return (o == 4'h8) || ((o >= 4'hA) && (o <= 4'hC));
`endif
  endfunction

  // Returns {carry, ovf, result}; carry doubles as borrow or shifted-out bit.
  function automatic logic [WIDTH+1:0] alu_calc(input logic [3:0] o,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             c, v;
    ext = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (o)
      4'h0: begin
        ext = {1'b0, a} + {1'b0, b};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1, 4'h9: begin
        ext = {1'b0, a} - {1'b0, b};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      4'h5: res = ~a;
      4'h6: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      4'h7: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      default: ;
    endcase
    return {c, v, res};
  endfunction

  assign trig_edge = trigger & ~trig_q;
  assign alu       = alu_calc(op_q, a_q, b_q);
  assign alu_res   = alu[WIDTH-1:0];
  assign alu_v     = alu[WIDTH];
  assign alu_c     = alu[WIDTH+1];
  assign view_a    = regs[sel_a];
  assign view_b    = regs[sel_b];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (trig_edge) begin
`ifdef ALU_MUL_EN
          state_d = (op == 4'h8) ? MUL : EXEC;
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC: state_d = IDLE;
`ifdef ALU_MUL_EN
      MUL:  if (mul_last) state_d = WB;
      WB:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef ALU_MUL_EN
      cnt    <= '0;
`endif
    end else begin
      trig_q <= trigger;
      done   <= 1'b0;
      case (state_q)
        // Capture: operands are snapshotted so later input changes are ignored.
        IDLE: begin
          if (trig_edge) begin
            op_q    <= op;
            a_q     <= regs[sel_a];
            b_q     <= regs[sel_b];
            sel_a_q <= sel_a;
            sel_b_q <= sel_b;
            sel_d_q <= sel_d;
            din_q   <= data_in;
`ifdef ALU_MUL_EN
            mcand   <= {{WIDTH{1'b0}}, regs[sel_a]};
            mplier  <= regs[sel_b];
            acc     <= '0;
            cnt     <= '0;
`endif
          end
        end
        // Single-cycle writeback.
        EXEC: begin
          done <= 1'b1;
          err  <= is_reserved(op_q);
          if (!is_reserved(op_q)) begin
            if (op_q <= 4'h9) begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              carry  <= alu_c;
              ovf    <= alu_v;
            end
            if (op_q <= 4'h8) regs[sel_d_q] <= alu_res;
            case (op_q)
              4'hD: regs[sel_d_q] <= din_q;
              4'hE: begin
                regs[sel_a_q] <= b_q;
                regs[sel_b_q] <= a_q;
              end
              4'hF: regs[sel_d_q] <= a_q;
              default: ;
            endcase
          end
        end
`ifdef ALU_MUL_EN
        // Shift-add step, one multiplier bit per cycle.
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        // Multiply writeback: low half to sel_d, high half to the next register.
        WB: begin
          done           <= 1'b1;
          err            <= 1'b0;
          regs[sel_d_q]  <= acc[WIDTH-1:0];
          regs[sel_hi]   <= acc[2*WIDTH-1:WIDTH];
          result         <= acc[WIDTH-1:0];
          zero           <= (acc[WIDTH-1:0] == '0);
          carry          <= |acc[2*WIDTH-1:WIDTH];
          ovf            <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Scoreboard bench for alu_regfile_ctrl: a reference model queues expected
// completions; a negedge monitor compares them when done pulses.
module tb_alu_regfile_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic [3:0] op;
  logic [1:0] sel_a, sel_b, sel_d;
  logic [7:0] data_in;
  logic [7:0] view_a, view_b, result;
  logic       zero, carry, ovf, busy, done, err;

  alu_regfile_ctrl #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .op(op),
    .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .data_in(data_in),
    .view_a(view_a), .view_b(view_b), .result(result),
    .zero(zero), .carry(carry), .ovf(ovf),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       z, c, v, e;
    int         cap;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;

  logic [7:0] m_reg [4];
  logic [7:0] m_res;
  logic       m_z, m_c, m_v, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t it;
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        it = sbq.pop_front();
        chk("result", result, it.res);
        chk("zero", zero, it.z);
        chk("carry", carry, it.c);
        chk("ovf", ovf, it.v);
        chk("err", err, it.e);
        chk("latency", cyc - it.cap, it.lat);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_res = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0; m_err = 1'b0;
  endtask

  task automatic model(input logic [3:0] o, input logic [1:0] sa, sb, sd, input logic [7:0] din);
    logic [7:0]  a, b, r, t;
    logic [15:0] p;
    logic [1:0]  hi;
    logic        rsv;
    int          si;
    exp_t        it;
    a = m_reg[sa];
    b = m_reg[sb];
    r = 8'h00;
    it.lat = 1;
`ifdef ALU_MUL_EN
    rsv = (o >= 4'hA) && (o <= 4'hC);
`else
    rsv = (o == 4'h8) || ((o >= 4'hA) && (o <= 4'hC));
`endif
    if (!rsv) begin
      case (o)
        4'h0: begin
          si = int'(a) + int'(b);
          r = si[7:0]; m_c = (si > 255);
          si = int'($signed(a)) + int'($signed(b));
          m_v = (si > 127) || (si < -128);
        end
        4'h1, 4'h9: begin
          r = a - b; m_c = (a < b);
          si = int'($signed(a)) - int'($signed(b));
          m_v = (si > 127) || (si < -128);
        end
        4'h2: begin r = a & b; m_c = 0; m_v = 0; end
        4'h3: begin r = a | b; m_c = 0; m_v = 0; end
        4'h4: begin r = a ^ b; m_c = 0; m_v = 0; end
        4'h5: begin r = 8'hFF - a; m_c = 0; m_v = 0; end
        4'h6: begin si = int'(a) * 2; r = si[7:0]; m_c = (a >= 8'h80); m_v = 0; end
        4'h7: begin r = a / 2; m_c = a[0]; m_v = 0; end
        4'h8: begin
          p = 16'(a) * 16'(b);
          r = p[7:0]; m_c = (p[15:8] != 0); m_v = 0;
          hi = sd + 2'd1;
          m_reg[hi] = p[15:8];
          it.lat = 9;
        end
        4'hD: m_reg[sd] = din;
        4'hE: begin t = m_reg[sa]; m_reg[sa] = m_reg[sb]; m_reg[sb] = t; end
        4'hF: m_reg[sd] = a;
        default: ;
      endcase
      if (o <= 4'h9) begin
        m_res = r;
        m_z = (r == 8'h00);
      end
      if (o <= 4'h8) m_reg[sd] = r;
    end
    m_err = rsv;
    it.res = m_res; it.z = m_z; it.c = m_c; it.v = m_v; it.e = m_err;
    it.cap = cyc + 1;
    sbq.push_back(it);
  endtask

  task automatic drive(input logic [3:0] o, input logic [1:0] sa, sb, sd, input logic [7:0] din);
    op = o; sel_a = sa; sel_b = sb; sel_d = sd; data_in = din;
    trigger = 1'b1;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [3:0] o, input logic [1:0] sa, sb, sd, input logic [7:0] din);
    model(o, sa, sb, sd, din);
    drive(o, sa, sb, sd, din);
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    chk("busy_after_capture", busy, 1);
    wait_done();
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      sel_b = 2'(3 - i);
      #1;
      chk("view_a", view_a, m_reg[i]);
      chk("view_b", view_b, m_reg[3 - i]);
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    reset = 1'b1; trigger = 1'b0; op = 4'h0;
    sel_a = 2'd0; sel_b = 2'd0; sel_d = 2'd0; data_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry, ovf}, 0);
    check_regs();

    run_cmd(4'hD, 0, 0, 0, 8'h7F);
    run_cmd(4'hD, 0, 0, 1, 8'h01);
    run_cmd(4'h0, 0, 1, 2, 8'h00);
    check_regs();
    chk("add_r2", m_reg[2], 8'h80);

    run_cmd(4'h1, 1, 0, 3, 8'h00);
    run_cmd(4'h9, 0, 0, 2, 8'h00);
    check_regs();

    run_cmd(4'hD, 0, 0, 0, 8'hFF);
    run_cmd(4'h0, 0, 1, 2, 8'h00);
    run_cmd(4'hD, 0, 0, 0, 8'h80);
    run_cmd(4'h1, 0, 1, 3, 8'h00);
    run_cmd(4'h6, 0, 0, 2, 8'h00);
    run_cmd(4'h7, 1, 0, 2, 8'h00);
    run_cmd(4'hE, 0, 1, 0, 8'h00);
    run_cmd(4'hE, 2, 2, 0, 8'h00);
    run_cmd(4'hF, 3, 0, 2, 8'h00);
    check_regs();

    for (int i = 0; i < 30; i++) begin
      run_cmd(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
      if (i % 5 == 4) check_regs();
    end

    run_cmd(4'hD, 0, 0, 1, 8'hFF);
`ifdef ALU_MUL_EN
    model(4'h8, 1, 1, 3, 8'h00);
    drive(4'h8, 1, 1, 3, 8'h00);
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    drive(4'hD, 0, 0, 1, 8'h55);
    @(negedge clk);
    trigger = 1'b0;
    wait_done();
    check_regs();
    chk("mul_r3", m_reg[3], 8'h01);
    chk("mul_r0", m_reg[0], 8'hFE);
`else
    run_cmd(4'h8, 1, 1, 3, 8'h00);
    check_regs();
`endif

    model(4'hD, 0, 0, 2, 8'h3C);
    drive(4'hD, 0, 0, 2, 8'h3C);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    chk("held_trigger_once", done_cnt - d0, 1);
    check_regs();

    run_cmd(4'hB, 0, 1, 2, 8'h00);
    check_regs();
    run_cmd(4'hD, 0, 0, 3, 8'h5A);
    check_regs();

    d0 = done_cnt;
`ifdef ALU_MUL_EN
    drive(4'h8, 0, 1, 2, 8'h00);
`else
    drive(4'hD, 0, 0, 2, 8'hAA);
`endif
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
`ifdef ALU_MUL_EN
    repeat (3) @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_err", err, 0);
    check_regs();
    chk("sbq_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
